// File: rtl/updown_pkg.sv
// Shared constants and FSM encoding for the command-driven up/down count sequencer.
package updown_pkg;

    localparam int WIDTH_DEFAULT = 5;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_UP       = 2'b01;
    localparam logic [1:0] OP_DOWN     = 2'b10;
    localparam logic [1:0] OP_PINGPONG = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN_UP   = 3'd1,
        ST_RUN_DOWN = 3'd2,
        ST_PP_UP    = 3'd3,
        ST_PP_DOWN  = 3'd4
    } state_e;

endpackage

// File: rtl/updown_if.sv
// Command handshake and status bundle between a host sequencer and updown_count_ctrl.
interface updown_if #(parameter int WIDTH = 5);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             hold;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, hold,
        input  cmd_ready, count, busy, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, hold,
        output cmd_ready, count, busy, done, wrap
    );

endinterface

// File: rtl/updown_core.sv
// WIDTH-bit wrap-around up/down count register with load and a look-ahead wrap flag.
module updown_core
    import updown_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             wrap_next
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

    // Count register: reset, then load, then step.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= ZERO;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= (dir == DIR_UP) ? (count + ONE) : (count - ONE);
        end else begin
            count <= count;
        end
    end

    // Flags a step that is about to cross the MAXV <-> 0 boundary.
    always_comb begin
        wrap_next = 1'b0;
        if (en && !load) begin
            wrap_next = (dir == DIR_UP) ? (count == MAXV) : (count == ZERO);
        end else begin
            wrap_next = 1'b0;
        end
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// Command sequencer: accepts LOAD/UP/DOWN/PINGPONG commands and schedules steps
// of one updown_core, reporting busy, done and wrap.
module updown_count_ctrl
    import updown_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic     clk,
    input  logic     reset,
    updown_if.slave  bus
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_next_s;
    logic [WIDTH-1:0] remaining_r;
    logic [WIDTH-1:0] remaining_next_s;
    logic             done_r;
    logic             done_next_s;
    logic             wrap_r;
    logic             load_s;
    logic             en_s;
    logic             dir_s;
    logic             wrap_next_s;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] count_inc_s;

    updown_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .load_val  (bus.cmd_arg),
        .en        (en_s),
        .dir       (dir_s),
        .count     (count_s),
        .wrap_next (wrap_next_s)
    );

    assign count_inc_s = count_s + ONE;

    // Next-state and step control; remaining_r holds the sweep peak in the PP states.
    always_comb begin
        state_next_s     = state_r;
        remaining_next_s = remaining_r;
        done_next_s      = 1'b0;
        load_s           = 1'b0;
        en_s             = 1'b0;
        dir_s            = DIR_UP;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_LOAD: begin
                            load_s      = 1'b1;
                            done_next_s = 1'b1;
                        end
                        OP_UP, OP_DOWN: begin
                            if (bus.cmd_arg == ZERO) begin
                                done_next_s = 1'b1;
                            end else begin
                                remaining_next_s = bus.cmd_arg;
                                state_next_s     = (bus.cmd_op == OP_UP) ? ST_RUN_UP : ST_RUN_DOWN;
                            end
                        end
                        OP_PINGPONG: begin
                            remaining_next_s = bus.cmd_arg;
                            state_next_s     = (count_s == bus.cmd_arg) ? ST_PP_DOWN : ST_PP_UP;
                        end
                        default: begin
                            state_next_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN_UP, ST_RUN_DOWN: begin
                if (!bus.hold) begin
                    en_s             = 1'b1;
                    dir_s            = (state_r == ST_RUN_UP) ? DIR_UP : DIR_DOWN;
                    remaining_next_s = remaining_r - ONE;
                    if (remaining_r == ONE) begin
                        done_next_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = state_r;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_PP_UP: begin
                if (!bus.hold) begin
                    en_s  = 1'b1;
                    dir_s = DIR_UP;
                    if (count_inc_s == remaining_r) begin
                        state_next_s = ST_PP_DOWN;
                    end else begin
                        state_next_s = ST_PP_UP;
                    end
                end else begin
                    state_next_s = ST_PP_UP;
                end
            end
            ST_PP_DOWN: begin
                // Entering at zero finishes without a step; otherwise finish on the step to zero.
                if (!bus.hold) begin
                    if (count_s == ZERO) begin
                        done_next_s  = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        en_s  = 1'b1;
                        dir_s = DIR_DOWN;
                        if (count_s == ONE) begin
                            done_next_s  = 1'b1;
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_PP_DOWN;
                        end
                    end
                end else begin
                    state_next_s = ST_PP_DOWN;
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                remaining_next_s = ZERO;
            end
        endcase
    end

    // State, step counter and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            remaining_r <= ZERO;
            done_r      <= 1'b0;
            wrap_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            remaining_r <= remaining_next_s;
            done_r      <= done_next_s;
            wrap_r      <= wrap_next_s;
        end
    end

    assign bus.cmd_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.count     = count_s;
    assign bus.done      = done_r;
    assign bus.wrap      = wrap_r;

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench for updown_count_ctrl: directed vectors with literal
// expectations plus a per-cycle comparison against a step-list model.
module tb_updown_count_ctrl;
    import updown_pkg::*;

    localparam int W    = 5;
    localparam int MOD  = 1 << W;
    localparam int MAXV = MOD - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    updown_if #(.WIDTH(W)) bus ();

    updown_count_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted command expands into the list of count values it will
    // visit; -1 marks a completion cycle with no step.
    int m_count = 0;
    bit m_done  = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_init  = 1'b0;
    int m_q[$];

    task automatic model_step();
        int v;
        int c;
        int n;
        if (reset === 1'b1) begin
            m_q.delete();
            m_count = 0;
            m_done  = 1'b0;
            m_wrap  = 1'b0;
            m_init  = 1'b1;
        end else begin
            m_done = 1'b0;
            m_wrap = 1'b0;
            if (m_q.size() == 0) begin
                if (bus.cmd_valid === 1'b1) begin
                    n = int'(bus.cmd_arg);
                    if (bus.cmd_op == OP_LOAD) begin
                        m_count = n;
                        m_done  = 1'b1;
                    end else if (bus.cmd_op == OP_UP || bus.cmd_op == OP_DOWN) begin
                        if (n == 0) m_done = 1'b1;
                        for (int i = 1; i <= n; i++)
                            m_q.push_back(bus.cmd_op == OP_UP ? (m_count + i) % MOD
                                                              : (m_count - i + MOD) % MOD);
                    end else begin
                        c = m_count;
                        while (c != n) begin
                            c = (c + 1) % MOD;
                            m_q.push_back(c);
                        end
                        if (c == 0) m_q.push_back(-1);
                        while (c > 0) begin
                            c--;
                            m_q.push_back(c);
                        end
                    end
                end
            end else if (bus.hold === 1'b0) begin
                v = m_q.pop_front();
                if (v >= 0) begin
                    m_wrap  = (m_count == MAXV && v == 0) || (m_count == 0 && v == MAXV);
                    m_count = v;
                end
                if (m_q.size() == 0) m_done = 1'b1;
            end
        end
    endtask

    // Advance the model at each active edge, compare the DUT on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (m_init) begin
                chk("model.count", bus.count, m_count);
                chk("model.busy", bus.busy, (m_q.size() != 0));
                chk("model.ready", bus.cmd_ready, (m_q.size() == 0));
                chk("model.done", bus.done, m_done);
                chk("model.wrap", bus.wrap, m_wrap);
            end
        end
    end

    task automatic peek(input string tag, input int c, input int b, input int d, input int w);
        chk({tag, ".count"}, bus.count, c);
        chk({tag, ".busy"}, bus.busy, b);
        chk({tag, ".ready"}, bus.cmd_ready, (b == 0) ? 1 : 0);
        chk({tag, ".done"}, bus.done, d);
        chk({tag, ".wrap"}, bus.wrap, w);
    endtask

    task automatic look(input string tag, input int c, input int b, input int d, input int w);
        peek(tag, c, b, d, w);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input int arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = W'(arg);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        int         arg;
    } cmd_t;

    cmd_t table_q[$];

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_arg   = '0;
        bus.hold      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        peek("reset", 0, 0, 0, 0);

        issue(OP_LOAD, 7);
        look("load7", 7, 0, 1, 0);
        peek("load7_after", 7, 0, 0, 0);

        issue(OP_LOAD, 30);
        issue(OP_UP, 3);
        look("up3.e0", 30, 1, 0, 0);
        look("up3.e1", 31, 1, 0, 0);
        look("up3.e2", 0, 1, 0, 1);
        peek("up3.e3", 1, 0, 1, 0);

        issue(OP_LOAD, 2);
        issue(OP_DOWN, 4);
        look("dn4.e0", 2, 1, 0, 0);
        bus.hold = 1'b1;
        look("dn4.e1", 1, 1, 0, 0);
        look("dn4.h1", 1, 1, 0, 0);
        bus.hold = 1'b0;
        look("dn4.h2", 1, 1, 0, 0);
        look("dn4.e4", 0, 1, 0, 0);
        look("dn4.e5", 31, 1, 0, 1);
        peek("dn4.e6", 30, 0, 1, 0);

        issue(OP_LOAD, 1);
        issue(OP_PINGPONG, 3);
        look("pp3.e0", 1, 1, 0, 0);
        look("pp3.e1", 2, 1, 0, 0);
        look("pp3.e2", 3, 1, 0, 0);
        look("pp3.e3", 2, 1, 0, 0);
        look("pp3.e4", 1, 1, 0, 0);
        peek("pp3.e5", 0, 0, 1, 0);

        issue(OP_LOAD, 12);
        issue(OP_UP, 0);
        peek("up0", 12, 0, 1, 0);
        issue(OP_DOWN, 1);
        look("dn1.e0", 12, 1, 0, 0);
        peek("dn1.e1", 11, 0, 1, 0);

        issue(OP_LOAD, 2);
        issue(OP_PINGPONG, 2);
        look("pp_eq.e0", 2, 1, 0, 0);
        look("pp_eq.e1", 1, 1, 0, 0);
        peek("pp_eq.e2", 0, 0, 1, 0);
        issue(OP_PINGPONG, 0);
        look("pp0.e0", 0, 1, 0, 0);
        peek("pp0.e1", 0, 0, 1, 0);

        issue(OP_LOAD, 20);
        issue(OP_DOWN, 10);
        look("rst_mid.e0", 20, 1, 0, 0);
        reset = 1'b1;
        look("rst_mid.e1", 19, 1, 0, 0);
        reset = 1'b0;
        look("rst_mid.r", 0, 0, 0, 0);
        look("rst_mid.r1", 0, 0, 0, 0);

        // Further sweeps and long runs with random holds, checked by the model alone.
        table_q.push_back('{OP_LOAD, 30});
        table_q.push_back('{OP_PINGPONG, 1});
        table_q.push_back('{OP_UP, 31});
        table_q.push_back('{OP_DOWN, 5});
        table_q.push_back('{OP_LOAD, 3});
        table_q.push_back('{OP_PINGPONG, 0});
        table_q.push_back('{OP_PINGPONG, 4});
        table_q.push_back('{OP_DOWN, 0});
        table_q.push_back('{OP_UP, 2});
        foreach (table_q[k]) begin
            issue(table_q[k].op, table_q[k].arg);
            for (int n = 0; n < 200 && bus.busy === 1'b1; n++) begin
                bus.hold = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            bus.hold = 1'b0;
            if (bus.busy !== 1'b0) chk("table.timeout", bus.busy, 0);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_count_ctrl.md
# updown_count_ctrl

Command-driven sequencer that owns a WIDTH-bit wrap-around up/down count register and steps it under program control. Commands (load, count up N, count down N, ping-pong sweep) arrive over a valid/ready handshake from a host or test sequencer. The block reports busy, a one-cycle done pulse and a wrap pulse. It replaces ad-hoc reset/preset/mode driving with a single scheduled interface.

## Interface
- WIDTH, 5: width of the count and of cmd_arg.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high iff FSM in IDLE.
- cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 PINGPONG.
- cmd_arg  in  WIDTH  LOAD value, step count (UP/DOWN) or sweep peak (PINGPONG).
- hold  in  1  freezes stepping while high; does not block acceptance.
- count  out  WIDTH  current count value.
- busy  out  1  command in progress (FSM not IDLE).
- done  out  1  one-cycle pulse: command finished.
- wrap  out  1  one-cycle pulse: last step wrapped (max->0 up, 0->max down).

## Operation
- Accept on rising edge with cmd_valid && cmd_ready; the edge is E0. Commands are ignored while reset is high.
- FSM states: IDLE, RUN_UP, RUN_DOWN, PP_UP, PP_DOWN.
- LOAD: count <= cmd_arg at E0, done set at E0, FSM stays IDLE.
- UP/DOWN, arg = 0: done set at E0, count unchanged, FSM stays IDLE, busy never rises.
- UP/DOWN, arg = N > 0: remaining <= N, go to RUN_UP/RUN_DOWN. Each edge with hold = 0 steps count by +1/-1 mod 2^WIDTH and decrements remaining. Set done and return to IDLE on the step where remaining reaches 0.
- PINGPONG, peak P:
  - If count == P at E0, go to PP_DOWN; otherwise go to PP_UP.
  - PP_UP steps +1, wrapping if needed, until count == P, then goes to PP_DOWN.
  - PP_DOWN steps -1 until count == 0, then sets done and returns to IDLE.
  - If PP_DOWN is entered with count already 0, done is set on the next edge with no step.
  - The PP_UP -> PP_DOWN transition costs no extra cycle: the step reaching P is followed directly by a down step.
- hold high: no step, remaining and state frozen, done/wrap held low.
- wrap is set on any step crossing 2^WIDTH-1 <-> 0.

## Timing
- Reset values, from the edge after reset is sampled high: count = 0, busy = 0, done = 0, wrap = 0, cmd_ready = 1, FSM = IDLE, remaining = 0.
- Reset mid-command aborts the command with no done pulse.
- All outputs are registered. cmd_ready and busy are decoded from state registers only.
- Latency for UP/DOWN N: the first step is visible after E1, the final count after EN. done is high during the cycle after EN, together with the final count.
- Held cycles add 1:1 to that latency.
- cmd_ready rises in the same cycle done is high, so back-to-back commands can be accepted on the next edge with no bubble.
- LOAD and zero-step commands: done is high in the cycle after E0, and cmd_ready never drops.
- wrap is high in the cycle after the wrapping step.
- done and wrap may be high together.

## Structure
- Package updown_pkg:
  - op encoding constants OP_LOAD, OP_UP, OP_DOWN, OP_PINGPONG.
  - FSM state typedef/encoding.
- Sub-module updown_core:
  - WIDTH-bit register with sync reset, load/load_val, en, dir.
  - Outputs count and a combinational wrap_next.
- updown_count_ctrl holds the FSM, the remaining-step counter, and the done/wrap registers, and instantiates one updown_core.

## Test plan
- Reset, then LOAD 7: count = 7 and done = 1 in the cycle after E0, busy stays 0, cmd_ready stays 1.
- LOAD 30, then UP 3: count goes 31, 0, 1. wrap pulses once, after the 31->0 step. done comes with count = 1, busy high 3 cycles.
- LOAD 2, then DOWN 4 with hold high for 2 cycles after the first step: count goes 1, (1, 1), 0, 31, 30. Completes in 6 cycles, wrap on 0->31, done with count = 30.
- LOAD 1, then PINGPONG 3: count goes 2, 3, 2, 1, 0. done with count = 0, no wrap.
- UP 0 from count 12: done in the cycle after E0, count stays 12, busy never high. A second command on the next edge is accepted.
- Reset asserted on the 2nd cycle of DOWN 10 from 20: the next cycle shows count = 0, busy = 0, cmd_ready = 1, and no done pulse at any point.
